// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one byte-addressed memory unit between the instruction-fetch (I) and data (D) ports.
// Optional wait-state abort is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_access_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IAck,
  output logic [31:0]       IRData,
  output logic              IErr,
  input  logic              DReq,
  input  logic              DRW,
  input  logic [1:0]        DSize,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DWData,
  output logic              DAck,
  output logic [31:0]       DRData,
  output logic              DErr,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemDataIn,
  output logic [1:0]        MemWordSel,
  input  logic [31:0]       MemDataOut,
  input  logic              MemMFC,
  output logic              Busy
);

  // state     | meaning
  // IDLE      | no transaction, arbitrate pending requests
  // ISSUE     | first cycle with Enable high, fields stable
  // WAIT_HI   | waiting for synchronized MFC to rise
  // WAIT_LO   | waiting for synchronized MFC to fall (data settled)
  // RESP      | Ack pulse to the granted port
  // RECOVER   | Enable low so the next access sees a fresh edge
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_access_arbiter: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]             state_q, state_d;
  logic                   rr_q, rr_d;
  logic                   gnt_q, gnt_d;
  logic                   grant;
  logic [SYNC_STAGES-1:0] mfc_sync_q, mfc_sync_d;
  logic                   mfc_s;
  logic                   mem_enable_q, mem_enable_d;
  logic                   mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic [1:0]             mem_sel_q, mem_sel_d;
  logic                   i_ack_q, i_ack_d;
  logic [31:0]            i_rdata_q, i_rdata_d;
  logic                   i_err_q, i_err_d;
  logic                   d_ack_q, d_ack_d;
  logic [31:0]            d_rdata_q, d_rdata_d;
  logic                   d_err_q, d_err_d;
  logic                   timeout;

  assign mfc_sync_d = {mfc_sync_q[SYNC_STAGES-2:0], MemMFC};
  assign mfc_s      = mfc_sync_q[SYNC_STAGES-1];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             in_wait;

  assign in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
  // >= so a late MFC rise on the last allowed cycle still aborts in WAIT_LO
  assign timeout = in_wait && (wait_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_ISSUE) begin
      wait_cnt_d = '0;
    end else if (in_wait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    grant        = PORT_I;
    mem_enable_d = mem_enable_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_sel_d    = mem_sel_q;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    i_err_d      = i_err_q;
    d_ack_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_err_d      = d_err_q;

    case (state_q)
      S_IDLE: begin
        if (IReq || DReq) begin
          if (IReq && DReq) grant = ~rr_q;
          else              grant = DReq ? PORT_D : PORT_I;
          gnt_d        = grant;
          rr_d         = grant;
          mem_enable_d = 1'b1;
          state_d      = S_ISSUE;
          if (grant == PORT_D) begin
            mem_rw_d    = DRW;
            mem_addr_d  = DAddr;
            mem_wdata_d = DWData;
            mem_sel_d   = DSize;
          end else begin
            mem_rw_d    = 1'b1;
            mem_addr_d  = IAddr;
            mem_wdata_d = '0;
            mem_sel_d   = 2'b10;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_HI;
      S_WAIT_HI, S_WAIT_LO: begin
        if (state_q == S_WAIT_HI && mfc_s) begin
          state_d = S_WAIT_LO;
        end else if (state_q == S_WAIT_LO && !mfc_s) begin
          state_d = S_RESP;
          if (gnt_q == PORT_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = MemDataOut;
            i_err_d   = 1'b0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rw_q ? MemDataOut : 32'h0;
            d_err_d   = 1'b0;
          end
        end else if (timeout) begin
          state_d      = S_RESP;
          mem_enable_d = 1'b0;
          if (gnt_q == PORT_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = 32'h0;
            i_err_d   = 1'b1;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = 32'h0;
            d_err_d   = 1'b1;
          end
        end
      end
      S_RESP: begin
        mem_enable_d = 1'b0;
        state_d      = S_RECOVER;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_q         <= PORT_I;
      gnt_q        <= PORT_I;
      mfc_sync_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= '0;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      mfc_sync_q   <= mfc_sync_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_sel_q    <= mem_sel_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      i_err_q      <= i_err_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign IAck         = i_ack_q;
  assign IRData       = i_rdata_q;
  assign IErr         = i_err_q;
  assign DAck         = d_ack_q;
  assign DRData       = d_rdata_q;
  assign DErr         = d_err_q;
  assign MemEnable    = mem_enable_q;
  assign MemReadWrite = mem_rw_q;
  assign MemAddress   = mem_addr_q;
  assign MemDataIn    = mem_wdata_q;
  assign MemWordSel   = mem_sel_q;
  assign Busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: randomized I/D traffic checked against a byte-array reference
// and a behavioural memory unit that answers Enable with an MFC pulse.
`timescale 1ns/1ps
module tb_mem_access_arbiter;
  localparam int AW = 32;
  localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int DLY_MAX = 2;
`else
  localparam int DLY_MAX = 3;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          IReq, IAck, IErr;
  logic [AW-1:0] IAddr;
  logic [31:0]   IRData;
  logic          DReq, DRW, DAck, DErr;
  logic [1:0]    DSize;
  logic [AW-1:0] DAddr;
  logic [31:0]   DWData, DRData;
  logic          MemEnable, MemReadWrite, MemMFC, Busy;
  logic [AW-1:0] MemAddress;
  logic [31:0]   MemDataIn, MemDataOut;
  logic [1:0]    MemWordSel;

  mem_access_arbiter #(.ADDR_W(AW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData), .IErr(IErr),
    .DReq(DReq), .DRW(DRW), .DSize(DSize), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData), .DErr(DErr),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
    .MemDataIn(MemDataIn), .MemWordSel(MemWordSel), .MemDataOut(MemDataOut),
    .MemMFC(MemMFC), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem_store [256];
  logic [7:0] ref_mem   [256];

  function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] sz);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    case (sz)
      2'b00:   return {24'h0, ref_mem[a]};
      2'b01:   return {16'h0, ref_mem[a], ref_mem[a1]};
      default: return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endcase
  endfunction

  function automatic void ref_write(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    case (sz)
      2'b00: ref_mem[a] = d[7:0];
      2'b01: begin ref_mem[a] = d[15:8]; ref_mem[a1] = d[7:0]; end
      default: begin
        ref_mem[a] = d[31:24]; ref_mem[a1] = d[23:16]; ref_mem[a2] = d[15:8]; ref_mem[a3] = d[7:0];
      end
    endcase
  endfunction

  // behavioural memory unit: reacts on the falling edge, MFC pulse after a programmable delay
  int          mm_delay = 1, mm_pulse = 1, mm_cnt = 0, n_issue = 0;
  bit          mm_rand = 0, mm_stuck = 0, mm_active = 0, mm_done = 0, mm_phase = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_rw;
  logic [1:0]  seen_sel;
  logic [7:0]  m0, m1, m2, m3;

  initial begin
    MemMFC = 1'b0;
    MemDataOut = 32'h0;
    forever begin
      @(negedge clk);
      if (!MemEnable) begin
        mm_active = 0; mm_done = 0; MemMFC = 1'b0;
      end else if (!mm_done) begin
        if (!mm_active) begin
          mm_active = 1; mm_phase = 0; n_issue++;
          if (mm_rand) begin
            mm_delay = $urandom_range(DLY_MAX, 0);
            mm_pulse = $urandom_range(DLY_MAX, 1);
          end
          mm_cnt = mm_delay;
          seen_addr = MemAddress; seen_rw = MemReadWrite; seen_sel = MemWordSel; seen_wdata = MemDataIn;
        end
        if (mm_phase == 0) begin
          if (mm_stuck) begin
            MemMFC = 1'b0;
          end else if (mm_cnt > 0) begin
            mm_cnt--;
          end else begin
            m0 = MemAddress[7:0]; m1 = m0 + 8'd1; m2 = m0 + 8'd2; m3 = m0 + 8'd3;
            if (MemReadWrite) begin
              case (MemWordSel)
                2'b00:   MemDataOut = {24'h0, mem_store[m0]};
                2'b01:   MemDataOut = {16'h0, mem_store[m0], mem_store[m1]};
                default: MemDataOut = {mem_store[m0], mem_store[m1], mem_store[m2], mem_store[m3]};
              endcase
            end else begin
              case (MemWordSel)
                2'b00: mem_store[m0] = MemDataIn[7:0];
                2'b01: begin mem_store[m0] = MemDataIn[15:8]; mem_store[m1] = MemDataIn[7:0]; end
                default: begin
                  mem_store[m0] = MemDataIn[31:24]; mem_store[m1] = MemDataIn[23:16];
                  mem_store[m2] = MemDataIn[15:8];  mem_store[m3] = MemDataIn[7:0];
                end
              endcase
              MemDataOut = $urandom();
            end
            MemMFC = 1'b1; mm_phase = 1; mm_cnt = mm_pulse;
          end
        end else begin
          if (mm_cnt > 1) mm_cnt--;
          else begin MemMFC = 1'b0; mm_done = 1; mm_active = 0; end
        end
      end
    end
  end

  // bus observer: ack counts, back-to-back acks, shortest Enable-low gap
  int n_iack = 0, n_dack = 0, consec = 0, min_gap = 1000, low_run = 0;
  bit prev_ack = 0, prev_en = 0, en_seen = 0;

  initial forever begin
    @(posedge clk); #1;
    if (IAck) n_iack++;
    if (DAck) n_dack++;
    if ((IAck || DAck) && prev_ack) consec++;
    prev_ack = IAck || DAck;
    if (MemEnable) begin
      if (!prev_en && en_seen && low_run < min_gap) min_gap = low_run;
      en_seen = 1; low_run = 0;
    end else begin
      low_run++;
    end
    prev_en = MemEnable;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d vectors, %0d miscompares", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    IReq = 0; DReq = 0; reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic i_txn(input logic [31:0] addr, output bit ok);
    IAddr = addr; IReq = 1; ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (IAck) begin ok = 1; break; end
    end
    IReq = 0;
  endtask

  task automatic d_txn(input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, output bit ok);
    DRW = rw; DSize = sz; DAddr = addr; DWData = wd; DReq = 1; ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (DAck) begin ok = 1; break; end
    end
    DReq = 0;
  endtask

  task automatic test_reset();
    IReq = 0; DReq = 0; IAddr = '0; DAddr = '0; DRW = 0; DSize = 0; DWData = 0;
    reset_n = 0; #1;
    n_vec++;
    if ({IAck, IErr, DAck, DErr, MemEnable, MemReadWrite, Busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000000",
                        {IAck, IErr, DAck, DErr, MemEnable, MemReadWrite, Busy});
    end
    n_vec++;
    if ({IRData, DRData, MemDataIn} !== 96'h0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h expected zeros", IRData, DRData, MemDataIn);
    end
    n_vec++;
    if ({MemAddress, MemWordSel} !== 34'h0) begin
      n_err++; $display("FAIL reset_addr: got %h/%b expected 0/00", MemAddress, MemWordSel);
    end
    apply_reset();
  endtask

  task automatic test_ifetch();
    bit ok; int n0;
    mem_store[8'h10] = 8'hDE; mem_store[8'h11] = 8'hAD; mem_store[8'h12] = 8'hBE; mem_store[8'h13] = 8'hEF;
    ref_mem[8'h10]   = 8'hDE; ref_mem[8'h11]   = 8'hAD; ref_mem[8'h12]   = 8'hBE; ref_mem[8'h13]   = 8'hEF;
    mm_rand = 0; mm_delay = 1; mm_pulse = 1;
    n0 = n_iack;
    i_txn(32'h10, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ifetch_ack: no IAck within 200 cycles"); end
    n_vec++;
    if (IRData !== 32'hDEADBEEF || IErr !== 1'b0) begin
      n_err++; $display("FAIL ifetch_data: got %h err=%b expected deadbeef err=0", IRData, IErr);
    end
    n_vec++;
    if (seen_sel !== 2'b10 || seen_rw !== 1'b1 || seen_addr !== 32'h10) begin
      n_err++; $display("FAIL ifetch_bus: got sel=%b rw=%b addr=%h expected 10/1/10", seen_sel, seen_rw, seen_addr);
    end
    repeat (4) @(posedge clk); #1;
    n_vec++;
    if (n_iack - n0 !== 1) begin n_err++; $display("FAIL ifetch_count: got %0d IAck pulses expected 1", n_iack - n0); end
  endtask

  task automatic test_write_read();
    bit ok;
    min_gap = 1000;
    d_txn(1'b0, 2'b10, 32'h20, 32'h12345678, ok);
    if (ok) ref_write(8'h20, 2'b10, 32'h12345678);
    n_vec++;
    if (!ok || DRData !== 32'h0 || DErr !== 1'b0) begin
      n_err++; $display("FAIL wr_resp: ok=%b got %h err=%b expected 00000000 err=0", ok, DRData, DErr);
    end
    n_vec++;
    if (seen_rw !== 1'b0 || seen_wdata !== 32'h12345678 || seen_addr !== 32'h20) begin
      n_err++; $display("FAIL wr_bus: got rw=%b data=%h addr=%h expected 0/12345678/20", seen_rw, seen_wdata, seen_addr);
    end
    d_txn(1'b1, 2'b10, 32'h20, $urandom(), ok);
    n_vec++;
    if (!ok || DRData !== ref_read(8'h20, 2'b10)) begin
      n_err++; $display("FAIL rd_back: ok=%b got %h expected %h", ok, DRData, ref_read(8'h20, 2'b10));
    end
    n_vec++;
    if (min_gap < 1) begin n_err++; $display("FAIL enable_gap: got %0d low cycles expected >=1", min_gap); end
  endtask

  task automatic test_arbitration();
    bit got_q[$];
    bit exp_q[$];
    bit last_d;
    int ri, rd;
    apply_reset();
    mm_rand = 1; consec = 0;
    last_d = 0; ri = 4; rd = 4;
    while (ri > 0 || rd > 0) begin
      bit g;
      if (ri > 0 && rd > 0) g = !last_d;
      else                  g = (rd > 0);
      exp_q.push_back(g); last_d = g;
      if (g) rd--; else ri--;
    end
    fork
      begin : i_side
        logic [7:0] ia; bit iok;
        for (int k = 0; k < 4; k++) begin
          ia = 8'($urandom_range(255, 0));
          IAddr = {24'h0, ia}; IReq = 1; iok = 0;
          for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (IAck) begin iok = 1; break; end
          end
          n_vec++;
          if (!iok) begin n_err++; $display("FAIL arb_i_ack k=%0d: got no IAck expected one", k); break; end
          got_q.push_back(1'b0);
          n_vec++;
          if (IRData !== ref_read(ia, 2'b10)) begin
            n_err++; $display("FAIL arb_i_data k=%0d: got %h expected %h", k, IRData, ref_read(ia, 2'b10));
          end
        end
        IReq = 0;
      end
      begin : d_side
        logic [7:0] da; bit dok;
        for (int k = 0; k < 4; k++) begin
          da = 8'($urandom_range(255, 0));
          DAddr = {24'h0, da}; DRW = 1; DSize = 2'b10; DReq = 1; dok = 0;
          for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (DAck) begin dok = 1; break; end
          end
          n_vec++;
          if (!dok) begin n_err++; $display("FAIL arb_d_ack k=%0d: got no DAck expected one", k); break; end
          got_q.push_back(1'b1);
          n_vec++;
          if (DRData !== ref_read(da, 2'b10)) begin
            n_err++; $display("FAIL arb_d_data k=%0d: got %h expected %h", k, DRData, ref_read(da, 2'b10));
          end
        end
        DReq = 0;
      end
    join
    for (int k = 0; k < exp_q.size(); k++) begin
      n_vec++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        n_err++;
        $display("FAIL arb_order idx=%0d: got %s expected %s", k,
                 (k >= got_q.size()) ? "none" : (got_q[k] ? "D" : "I"), exp_q[k] ? "D" : "I");
      end
    end
    n_vec++;
    if (consec !== 0) begin n_err++; $display("FAIL ack_spacing: got %0d consecutive-cycle acks expected 0", consec); end
  endtask

  task automatic test_narrow_read();
    bit ok;
    mem_store[8'h40] = 8'hA5; mem_store[8'h41] = 8'h3C; mem_store[8'h42] = 8'hFF; mem_store[8'h43] = 8'h81;
    ref_mem[8'h40]   = 8'hA5; ref_mem[8'h41]   = 8'h3C; ref_mem[8'h42]   = 8'hFF; ref_mem[8'h43]   = 8'h81;
    mm_rand = 1;
    d_txn(1'b1, 2'b00, 32'h40, 32'h0, ok);
    n_vec++;
    if (!ok || DRData !== 32'h000000A5) begin
      n_err++; $display("FAIL byte_read: ok=%b got %h expected 000000a5", ok, DRData);
    end
    n_vec++;
    if (seen_sel !== 2'b00) begin n_err++; $display("FAIL byte_sel: got %b expected 00", seen_sel); end
    d_txn(1'b1, 2'b01, 32'h41, 32'h0, ok);
    n_vec++;
    if (!ok || DRData !== 32'h00003CFF || seen_sel !== 2'b01) begin
      n_err++; $display("FAIL half_read: ok=%b got %h sel=%b expected 00003cff sel=01", ok, DRData, seen_sel);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_i, exp_d, wd, exp_v;
    logic [7:0]  a;
    logic [1:0]  sz;
    logic        rw;
    bit          ok;
    int          iss0;
    apply_reset();
    exp_i = 32'h0; exp_d = 32'h0; mm_rand = 1;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom_range(255, 0));
      iss0 = n_issue;
      if ($urandom_range(1, 0) == 0) begin
        i_txn({24'h0, a}, ok);
        exp_i = ref_read(a, 2'b10);
        n_vec++;
        if (!ok || IRData !== exp_i || IErr !== 1'b0 || DRData !== exp_d) begin
          n_err++; $display("FAIL rand_i k=%0d: ok=%b got %h/%b dhold=%h expected %h/0 dhold=%h",
                            k, ok, IRData, IErr, DRData, exp_i, exp_d);
        end
        n_vec++;
        if (seen_sel !== 2'b10 || seen_addr !== {24'h0, a} || n_issue - iss0 !== 1) begin
          n_err++; $display("FAIL rand_i_bus k=%0d: got sel=%b addr=%h issues=%0d expected 10/%h/1",
                            k, seen_sel, seen_addr, n_issue - iss0, a);
        end
      end else begin
        rw = 1'($urandom_range(1, 0));
        sz = 2'($urandom_range(3, 0));
        wd = $urandom();
        d_txn(rw, sz, {24'h0, a}, wd, ok);
        if (rw) exp_v = ref_read(a, sz);
        else begin exp_v = 32'h0; if (ok) ref_write(a, sz, wd); end
        exp_d = exp_v;
        n_vec++;
        if (!ok || DRData !== exp_d || DErr !== 1'b0 || IRData !== exp_i) begin
          n_err++; $display("FAIL rand_d k=%0d rw=%b sz=%b: ok=%b got %h/%b ihold=%h expected %h/0 ihold=%h",
                            k, rw, sz, ok, DRData, DErr, IRData, exp_d, exp_i);
        end
        n_vec++;
        if (seen_sel !== sz || seen_rw !== rw || seen_addr !== {24'h0, a} || seen_wdata !== wd) begin
          n_err++; $display("FAIL rand_d_bus k=%0d: got sel=%b rw=%b addr=%h wd=%h expected %b/%b/%h/%h",
                            k, seen_sel, seen_rw, seen_addr, seen_wdata, sz, rw, a, wd);
        end
      end
    end
  endtask

  task automatic test_reset_wait_lo();
    bit ok, rose;
    int a0;
    mm_rand = 0; mm_delay = 0; mm_pulse = 5; rose = 0;
    IAddr = 32'h10; IReq = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (MemMFC) begin rose = 1; break; end
    end
    n_vec++;
    if (!rose) begin n_err++; $display("FAIL rst_mfc: got no MFC rise expected one"); end
    repeat (4) @(posedge clk);
    #2;
    a0 = n_iack + n_dack;
    reset_n = 0; #1;
    n_vec++;
    if (MemEnable !== 1'b0 || Busy !== 1'b0 || IAck !== 1'b0) begin
      n_err++; $display("FAIL rst_async: got en=%b busy=%b iack=%b expected 0/0/0", MemEnable, Busy, IAck);
    end
    IReq = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1;
    repeat (6) @(posedge clk); #1;
    n_vec++;
    if (n_iack + n_dack !== a0) begin n_err++; $display("FAIL rst_noack: got %0d acks expected 0", n_iack + n_dack - a0); end
    mm_pulse = 1; mm_delay = 1;
    i_txn(32'h10, ok);
    n_vec++;
    if (!ok || IRData !== ref_read(8'h10, 2'b10)) begin
      n_err++; $display("FAIL rst_recover: ok=%b got %h expected %h", ok, IRData, ref_read(8'h10, 2'b10));
    end
  endtask

  task automatic test_timeout();
    bit ok;
`ifdef MEM_ARB_TIMEOUT_EN
    int issue_c, ack_c;
    bit en_at_ack;
    mm_rand = 0; mm_stuck = 1; issue_c = -1; ack_c = -1; en_at_ack = 1; ok = 0;
    DAddr = 32'h20; DRW = 1; DSize = 2'b10; DReq = 1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (MemEnable && issue_c < 0) issue_c = c;
      if (DAck) begin ok = 1; ack_c = c; en_at_ack = MemEnable; break; end
    end
    DReq = 0;
    n_vec++;
    if (!ok || DErr !== 1'b1 || DRData !== 32'h0) begin
      n_err++; $display("FAIL timeout_resp: ok=%b got err=%b data=%h expected 1/00000000", ok, DErr, DRData);
    end
    n_vec++;
    if (ack_c - issue_c !== TO + 1 || en_at_ack !== 1'b0) begin
      n_err++; $display("FAIL timeout_lat: got %0d cycles en=%b expected %0d en=0", ack_c - issue_c, en_at_ack, TO + 1);
    end
    mm_stuck = 0; mm_delay = 1; mm_pulse = 1;
    repeat (3) @(posedge clk); #1;
    d_txn(1'b1, 2'b10, 32'h20, 32'h0, ok);
    n_vec++;
    if (!ok || DErr !== 1'b0 || DRData !== ref_read(8'h20, 2'b10)) begin
      n_err++; $display("FAIL timeout_clear: ok=%b got err=%b data=%h expected 0/%h", ok, DErr, DRData, ref_read(8'h20, 2'b10));
    end
`else
    mm_rand = 0; mm_delay = 80; mm_pulse = 2;
    d_txn(1'b1, 2'b10, 32'h20, 32'h0, ok);
    n_vec++;
    if (!ok || DErr !== 1'b0 || DRData !== ref_read(8'h20, 2'b10)) begin
      n_err++; $display("FAIL slow_mem: ok=%b got err=%b data=%h expected 0/%h", ok, DErr, DRData, ref_read(8'h20, 2'b10));
    end
    mm_delay = 1; mm_pulse = 1;
`endif
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(255, 0));
      mem_store[i] = b; ref_mem[i] = b;
    end
    test_reset();
    test_ifetch();
    test_write_read();
    test_arbitration();
    test_narrow_read();
    test_random();
    test_reset_wait_lo();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
